// File: rtl/vmicro16_cluster_apb_arbiter_pkg.sv
// Shared definitions for the cluster APB arbiter: FSM encodings, abort data, counter width.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
package vmicro16_cluster_apb_arbiter_pkg;

  // Arbiter FSM state encodings.
  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_SETUP  = 2'd1,
    ARB_ACCESS = 2'd2,
    ARB_RESP   = 2'd3
  } arb_state_t;

  // Width of the ACCESS-phase timeout counter.
  localparam int ARB_CNT_W = 8;

  // Read data returned to a cluster when a transfer is aborted by timeout.
  // Sliced down to DATA_WIDTH at the point of use.
  localparam logic [63:0] ARB_ABORT_DATA = 64'hFFFF_FFFF_FFFF_FFFF;

  // Width of a grant index; at least 1 bit so single-cluster builds stay legal.
  function automatic int grant_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/vmicro16_cluster_apb_arbiter_rr_arbiter.sv
// Combinational round-robin grant: first requester after last_grant, wrapping modulo NCLUSTERS.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; caller samples grant/vld only when it is ready to start a transfer.
//
// Ports:
//   req        in  NCLUSTERS  request vector (one bit per cluster)
//   last_grant in  GW         index of the most recently granted cluster
//   grant      out GW         winning cluster index (valid only when vld=1)
//   vld        out 1          at least one request is pending
module vmicro16_rr_arbiter
  import vmicro16_cluster_apb_arbiter_pkg::*;
#(
  parameter int NCLUSTERS = 2,
  localparam int GW = grant_w(NCLUSTERS)
) (
  input  logic [NCLUSTERS-1:0] req,
  input  logic [GW-1:0]        last_grant,
  output logic [GW-1:0]        grant,
  output logic                 vld
);

  logic [GW-1:0] idx;

  // Scan starts one past last_grant and visits last_grant itself last,
  // so a lone requester is always served.
  always_comb begin
    grant = '0;
    vld   = 1'b0;
    idx   = '0;
    for (int i = 1; i <= NCLUSTERS; i++) begin
      idx = GW'((int'(last_grant) + i) % NCLUSTERS);
      if (!vld && req[idx]) begin
        vld   = 1'b1;
        grant = idx;
      end
    end
  end

endmodule

// File: rtl/vmicro16_cluster_apb_arbiter.sv
// Round-robin arbiter folding NCLUSTERS cluster APB masters onto one registered APB master port.
// Latency: 4 cycles per transfer (IDLE grant, SETUP, ACCESS, RESP) plus soc wait states.
// Backpressure: losing clusters see S_PREADY=0 and stall in ACCESS; soc stalls via M_PREADY.
//
// Optional feature macro: VMICRO16_CLUSTER_ARB_TIMEOUT_EN
//   defined   -> ACCESS aborts after TIMEOUT_CYCLES without M_PREADY, returns all-ones,
//                sets sticky timeout_err (port present).
//   undefined -> ACCESS waits indefinitely; no timeout_err port.
//
// Ports:
//   clk, reset (async active-low)
//   S_PADDR/S_PWRITE/S_PSELx/S_PENABLE/S_PWDATA  in   per-cluster APB request lanes
//   S_PRDATA/S_PREADY                            out  per-cluster registered response
//   M_PADDR/M_PWRITE/M_PSELx/M_PENABLE/M_PWDATA  out  registered APB master to soc IC_DMEM
//   M_PRDATA/M_PREADY                            in   soc response
//   timeout_err                                  out  sticky timeout flag (macro only)
module vmicro16_cluster_apb_arbiter
  import vmicro16_cluster_apb_arbiter_pkg::*;
#(
  parameter int NCLUSTERS      = 2,
  parameter int BUS_WIDTH      = 16,
  parameter int DATA_WIDTH     = 16,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [NCLUSTERS*BUS_WIDTH-1:0]  S_PADDR,
  input  logic [NCLUSTERS-1:0]            S_PWRITE,
  input  logic [NCLUSTERS-1:0]            S_PSELx,
  input  logic [NCLUSTERS-1:0]            S_PENABLE,
  input  logic [NCLUSTERS*DATA_WIDTH-1:0] S_PWDATA,
  output logic [NCLUSTERS*DATA_WIDTH-1:0] S_PRDATA,
  output logic [NCLUSTERS-1:0]            S_PREADY,
  output logic [BUS_WIDTH-1:0]            M_PADDR,
  output logic                            M_PWRITE,
  output logic                            M_PSELx,
  output logic                            M_PENABLE,
  output logic [DATA_WIDTH-1:0]           M_PWDATA,
  input  logic [DATA_WIDTH-1:0]           M_PRDATA,
  input  logic                            M_PREADY
`ifdef VMICRO16_CLUSTER_ARB_TIMEOUT_EN
  ,
  output logic                            timeout_err
`endif
);

  localparam int GW = grant_w(NCLUSTERS);

  arb_state_t                      state_q, state_d;
  logic [GW-1:0]                   last_grant_q, last_grant_d;
  logic [BUS_WIDTH-1:0]            paddr_q, paddr_d;
  logic                            pwrite_q, pwrite_d;
  logic [DATA_WIDTH-1:0]           pwdata_q, pwdata_d;
  logic [NCLUSTERS-1:0]            s_pready_q, s_pready_d;
  logic [NCLUSTERS*DATA_WIDTH-1:0] s_prdata_q, s_prdata_d;

  logic [GW-1:0]                   rr_grant;
  logic                            rr_vld;

`ifdef VMICRO16_CLUSTER_ARB_TIMEOUT_EN
  logic [ARB_CNT_W-1:0]            cnt_q, cnt_d;
  logic                            timeout_err_q, timeout_err_d;
`endif

  vmicro16_rr_arbiter #(
    .NCLUSTERS (NCLUSTERS)
  ) u_rr_arbiter (
    .req        (S_PSELx),
    .last_grant (last_grant_q),
    .grant      (rr_grant),
    .vld        (rr_vld)
  );

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    paddr_d      = paddr_q;
    pwrite_d     = pwrite_q;
    pwdata_d     = pwdata_q;
    // Response lanes are single-cycle pulses; they clear unless set below.
    s_pready_d   = '0;
    s_prdata_d   = '0;
`ifdef VMICRO16_CLUSTER_ARB_TIMEOUT_EN
    cnt_d         = cnt_q;
    timeout_err_d = timeout_err_q;
`endif

    unique case (state_q)
      ARB_IDLE: begin
        if (rr_vld) begin
          last_grant_d = rr_grant;
          paddr_d      = S_PADDR[int'(rr_grant)*BUS_WIDTH +: BUS_WIDTH];
          pwrite_d     = S_PWRITE[rr_grant];
          pwdata_d     = S_PWDATA[int'(rr_grant)*DATA_WIDTH +: DATA_WIDTH];
          state_d      = ARB_SETUP;
        end
      end
      ARB_SETUP: begin
        state_d = ARB_ACCESS;
`ifdef VMICRO16_CLUSTER_ARB_TIMEOUT_EN
        cnt_d   = '0;
`endif
      end
      ARB_ACCESS: begin
        // The granted cluster's S_PSELx is not consulted here: once started,
        // a transfer always runs to a response even if the cluster drops it.
        if (M_PREADY) begin
          s_pready_d[last_grant_q] = 1'b1;
          s_prdata_d[int'(last_grant_q)*DATA_WIDTH +: DATA_WIDTH] =
            pwrite_q ? '0 : M_PRDATA;
          state_d = ARB_RESP;
        end
`ifdef VMICRO16_CLUSTER_ARB_TIMEOUT_EN
        else begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_d == ARB_CNT_W'(TIMEOUT_CYCLES)) begin
            s_pready_d[last_grant_q] = 1'b1;
            s_prdata_d[int'(last_grant_q)*DATA_WIDTH +: DATA_WIDTH] =
              ARB_ABORT_DATA[DATA_WIDTH-1:0];
            timeout_err_d = 1'b1;
            state_d       = ARB_RESP;
          end
        end
`endif
      end
      ARB_RESP: begin
        state_d = ARB_IDLE;
      end
      default: begin
        state_d = ARB_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ARB_IDLE;
      // Start at the last lane so cluster 0 wins the first arbitration.
      last_grant_q <= GW'(NCLUSTERS - 1);
      paddr_q      <= '0;
      pwrite_q     <= 1'b0;
      pwdata_q     <= '0;
      s_pready_q   <= '0;
      s_prdata_q   <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      paddr_q      <= paddr_d;
      pwrite_q     <= pwrite_d;
      pwdata_q     <= pwdata_d;
      s_pready_q   <= s_pready_d;
      s_prdata_q   <= s_prdata_d;
    end
  end

`ifdef VMICRO16_CLUSTER_ARB_TIMEOUT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q         <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      cnt_q         <= cnt_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign timeout_err = timeout_err_q;
`else
  // Timeout configuration has no effect in this build.
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES == 0) ^ ARB_ABORT_DATA[0] ^ (ARB_CNT_W == 0);
`endif

  // Cluster PENABLE carries no information the arbiter needs: SETUP/ACCESS
  // are regenerated downstream from the arbiter's own state.
  logic unused_s_penable;
  assign unused_s_penable = ^S_PENABLE;

  // Master-side controls decode straight from flops, so nothing upstream
  // reaches the soc combinationally.
  assign M_PSELx   = (state_q == ARB_SETUP) || (state_q == ARB_ACCESS);
  assign M_PENABLE = (state_q == ARB_ACCESS);
  assign M_PADDR   = paddr_q;
  assign M_PWRITE  = pwrite_q;
  assign M_PWDATA  = pwdata_q;
  assign S_PREADY  = s_pready_q;
  assign S_PRDATA  = s_prdata_q;

endmodule

// File: tb/tb_vmicro16_cluster_apb_arbiter.sv
// Directed self-checking bench for the cluster APB arbiter.
// Latency: checks the 4-cycle minimum transfer and wait-state stretching.
// Backpressure: exercises contention, soc wait states, reset abort, timeout.
module tb_vmicro16_cluster_apb_arbiter;

  localparam int NC = 2;
  localparam int BW = 16;
  localparam int DW = 16;

  logic           clk = 1'b0;
  logic           reset;
  logic [NC*BW-1:0] s_paddr;
  logic [NC-1:0]    s_pwrite;
  logic [NC-1:0]    s_pselx;
  logic [NC-1:0]    s_penable;
  logic [NC*DW-1:0] s_pwdata;
  logic [NC*DW-1:0] s_prdata;
  logic [NC-1:0]    s_pready;
  logic [BW-1:0]    m_paddr;
  logic             m_pwrite;
  logic             m_pselx;
  logic             m_penable;
  logic [DW-1:0]    m_pwdata;
  logic [DW-1:0]    m_prdata;
  logic             m_pready;
`ifdef VMICRO16_CLUSTER_ARB_TIMEOUT_EN
  logic             timeout_err;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  vmicro16_cluster_apb_arbiter #(
    .NCLUSTERS      (NC),
    .BUS_WIDTH      (BW),
    .DATA_WIDTH     (DW),
    .TIMEOUT_CYCLES (4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .S_PADDR   (s_paddr),
    .S_PWRITE  (s_pwrite),
    .S_PSELx   (s_pselx),
    .S_PENABLE (s_penable),
    .S_PWDATA  (s_pwdata),
    .S_PRDATA  (s_prdata),
    .S_PREADY  (s_pready),
    .M_PADDR   (m_paddr),
    .M_PWRITE  (m_pwrite),
    .M_PSELx   (m_pselx),
    .M_PENABLE (m_penable),
    .M_PWDATA  (m_pwdata),
    .M_PRDATA  (m_prdata),
    .M_PREADY  (m_pready)
`ifdef VMICRO16_CLUSTER_ARB_TIMEOUT_EN
    ,
    .timeout_err (timeout_err)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    tick();
  endtask

  initial begin
    logic saw_pready;
    reset     = 1'b0;
    s_paddr   = '0;
    s_pwrite  = '0;
    s_pselx   = '0;
    s_penable = '0;
    s_pwdata  = '0;
    m_prdata  = '0;
    m_pready  = 1'b0;
    tick();
    tick();

    // Reset state
    check("rst_m_pselx",   m_pselx,   0);
    check("rst_m_penable", m_penable, 0);
    check("rst_s_pready",  s_pready,  0);
    check("rst_s_prdata",  s_prdata,  0);
    check("rst_m_paddr",   m_paddr,   0);
    reset = 1'b1;
    tick();

    // Single read: cluster 0 reads 0x0123, soc returns 0xBEEF immediately
    s_paddr  = {16'h7777, 16'h0123};
    s_pselx  = 2'b01;
    m_pready = 1'b1;
    m_prdata = 16'hBEEF;
    check("rd_c0_pselx", m_pselx, 0);
    tick();
    check("rd_c1_pselx",   m_pselx,   1);
    check("rd_c1_penable", m_penable, 0);
    check("rd_c1_paddr",   m_paddr,   16'h0123);
    check("rd_c1_pwrite",  m_pwrite,  0);
    tick();
    check("rd_c2_penable", m_penable, 1);
    check("rd_c2_paddr",   m_paddr,   16'h0123);
    check("rd_c2_spready", s_pready,  0);
    tick();
    check("rd_c3_spready", s_pready,  2'b01);
    check("rd_c3_sprdata", s_prdata,  32'h0000_BEEF);
    check("rd_c3_pselx",   m_pselx,   0);
    s_pselx = 2'b00;
    tick();
    check("rd_c4_spready", s_pready,  0);
    check("rd_c4_pselx",   m_pselx,   0);

    // Write with 3 wait states: cluster 1 writes 0x5A5A to 0x0040
    s_paddr  = {16'h0040, 16'h0999};
    s_pwdata = {16'h5A5A, 16'h1234};
    s_pwrite = 2'b10;
    s_pselx  = 2'b10;
    m_pready = 1'b0;
    m_prdata = 16'h1111;
    tick();
    check("wr_c1_pselx",   m_pselx,   1);
    check("wr_c1_penable", m_penable, 0);
    check("wr_c1_paddr",   m_paddr,   16'h0040);
    check("wr_c1_pwrite",  m_pwrite,  1);
    check("wr_c1_pwdata",  m_pwdata,  16'h5A5A);
    for (int c = 2; c <= 5; c++) begin
      tick();
      check($sformatf("wr_c%0d_penable", c), m_penable, 1);
      check($sformatf("wr_c%0d_pwdata", c),  m_pwdata,  16'h5A5A);
      check($sformatf("wr_c%0d_pwrite", c),  m_pwrite,  1);
      check($sformatf("wr_c%0d_spready", c), s_pready,  0);
      m_pready = (c == 5);
    end
    tick();
    check("wr_c6_spready", s_pready, 2'b10);
    check("wr_c6_sprdata", s_prdata, 0);
    check("wr_c6_pselx",   m_pselx,  0);
    s_pselx  = 2'b00;
    s_pwrite = 2'b00;
    tick();
    check("wr_c7_spready", s_pready, 0);

    // Contention: both clusters request continuously just after reset
    do_reset();
    s_paddr  = {16'h0B00, 16'h0A00};
    s_pselx  = 2'b11;
    m_pready = 1'b1;
    for (int c = 0; c < 16; c++) begin
      int g;
      g = (c / 4) % 2;
      check($sformatf("rr_c%0d_spready", c), s_pready, (c % 4 == 3) ? (1 << g) : 0);
      if (c % 4 == 1)
        check($sformatf("rr_c%0d_paddr", c), m_paddr, (g == 0) ? 16'h0A00 : 16'h0B00);
      tick();
    end
    s_pselx = 2'b00;
    tick();
    tick();

    // Reset asserted mid-ACCESS
    s_paddr  = {16'h0B00, 16'h0A00};
    s_pselx  = 2'b10;
    m_pready = 1'b0;
    tick();
    tick();
    check("rstmid_penable_before", m_penable, 1);
    reset = 1'b0;
    #1;
    check("rstmid_pselx",   m_pselx,   0);
    check("rstmid_penable", m_penable, 0);
    check("rstmid_spready", s_pready,  0);
    #2;
    reset    = 1'b1;
    s_pselx  = 2'b11;
    m_pready = 1'b1;
    tick();
    check("rstmid_regrant_paddr", m_paddr, 16'h0A00);
    tick();
    tick();
    check("rstmid_regrant_spready", s_pready, 2'b01);
    s_pselx = 2'b00;
    tick();
    tick();

    // Timeout behaviour: soc never asserts PREADY
    do_reset();
    s_paddr  = {16'h0000, 16'h0321};
    s_pwrite = 2'b00;
    s_pselx  = 2'b01;
    m_pready = 1'b0;
`ifdef VMICRO16_CLUSTER_ARB_TIMEOUT_EN
    for (int c = 1; c <= 5; c++) tick();
    check("to_c5_penable", m_penable,   1);
    check("to_c5_err",     timeout_err, 0);
    tick();
    check("to_c6_spready", s_pready,    2'b01);
    check("to_c6_sprdata", s_prdata,    32'h0000_FFFF);
    check("to_c6_pselx",   m_pselx,     0);
    check("to_c6_err",     timeout_err, 1);
    s_pselx = 2'b00;
    repeat (4) tick();
    check("to_err_sticky", timeout_err, 1);
    reset = 1'b0;
    #1;
    check("to_err_cleared", timeout_err, 0);
    reset = 1'b1;
    tick();
`else
    saw_pready = 1'b0;
    for (int c = 0; c < 300; c++) begin
      tick();
      saw_pready = saw_pready | (|s_pready);
    end
    check("noto_penable",    m_penable,  1);
    check("noto_pselx",      m_pselx,    1);
    check("noto_no_spready", saw_pready, 0);
    s_pselx = 2'b00;
    do_reset();
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
